// File: rtl/tensor_core_stream_controller.sv
// Instruction/burst controller for the tensor core: decodes commands in IDLE,
// streams operand matrices in, result-buffer beats out, and runs the
// start/done handshake with the tensor core.
// Optional feature macro: TENSOR_CORE_STREAM_AUTO_OPERATE_EN (write bursts
// chain straight into OPERATE using command bits [5:4] as the select).
module tensor_core_stream_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 3,
  parameter int unsigned LANES      = 2
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic [LANES*DATA_WIDTH-1:0]    instruction_in,
  output logic [LANES*DATA_WIDTH-1:0]    controller_output_out,
  output logic                           output_valid_out,
  output logic                           busy_out,
  output logic                           tensor_core_start_out,
  output logic [1:0]                     tensor_core_select_out,
  input  logic                           tensor_core_done_in,
  output logic [DIM*DIM*DATA_WIDTH-1:0]  tensor_core_input1_out,
  output logic [DIM*DIM*DATA_WIDTH-1:0]  tensor_core_input2_out,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]  tensor_core_result_in
);

  localparam int unsigned W  = LANES * DATA_WIDTH;
  localparam int unsigned NE = DIM * DIM;
  localparam int unsigned MW = NE * DATA_WIDTH;
  localparam int unsigned BW = (2 * NE + LANES - 1) / LANES;
  localparam int unsigned B1 = (NE + LANES - 1) / LANES;
  localparam int unsigned BR = (NE + LANES - 1) / LANES;
  localparam int unsigned CW = $clog2(BW + 1);

  localparam logic [1:0] OP_OPERATE = 2'b01;
  localparam logic [1:0] OP_BURST   = 2'b10;

  localparam logic [1:0] BS_READ       = 2'b00;
  localparam logic [1:0] BS_WRITE      = 2'b01;
  localparam logic [1:0] BS_READ_WRITE = 2'b10;
  localparam logic [1:0] BS_M1_WRITE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WRITE,
    S_OPERATE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m1only_q, m1only_d;
  logic [MW-1:0]   m1_q, m1_d;
  logic [MW-1:0]   m2_q, m2_d;
  logic [MW-1:0]   res_q, res_d;
  logic [W-1:0]    out_q, out_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic [1:0]      sel_q, sel_d;

  logic            rd_en_c;
  logic            wr_en_c;
  int unsigned     rd_idx_c;
  int unsigned     rd_next_c;
  logic [W-1:0]    rd_data_c;
  logic            wr_last_c;

  // State and datapath registers
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      m1only_q <= 1'b0;
      m1_q     <= '0;
      m2_q     <= '0;
      res_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      sel_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m1only_q <= m1only_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      res_q    <= res_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      sel_q    <= sel_d;
    end
  end

  // Command decode, beat sequencing and storage/result updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m1only_d  = m1only_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    res_d     = res_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    sel_d     = sel_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    rd_idx_c  = 0;
    rd_next_c = 32'(cnt_q) + 32'd1;
    rd_data_c = '0;
    wr_last_c = m1only_q ? (cnt_q == CW'(B1 - 1)) : (cnt_q == CW'(BW - 1));

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (instruction_in[1:0] == OP_OPERATE) begin
          sel_d   = instruction_in[3:2];
          start_d = 1'b1;
          state_d = S_OPERATE;
        end else if (instruction_in[1:0] == OP_BURST) begin
          case (instruction_in[3:2])
            BS_READ: begin
              rd_en_c = 1'b1;
              state_d = (BR > 1) ? S_READ : S_IDLE;
            end
            BS_WRITE, BS_M1_WRITE: begin
              m1only_d = (instruction_in[3:2] == BS_M1_WRITE);
              state_d  = S_WRITE;
`ifdef TENSOR_CORE_STREAM_AUTO_OPERATE_EN
              sel_d    = instruction_in[5:4];
`endif
            end
            BS_READ_WRITE: begin
              rd_en_c  = 1'b1;
              m1only_d = 1'b0;
              state_d  = S_READ_WRITE;
            end
            default: ;
          endcase
        end
      end

      S_WRITE: begin
        wr_en_c = 1'b1;
        if (wr_last_c) begin
          cnt_d = '0;
`ifdef TENSOR_CORE_STREAM_AUTO_OPERATE_EN
          state_d = S_OPERATE;
          start_d = 1'b1;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_READ: begin
        rd_en_c  = 1'b1;
        rd_idx_c = rd_next_c;
        if (rd_next_c >= BR - 1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_READ_WRITE: begin
        wr_en_c = 1'b1;
        if (rd_next_c < BR) begin
          rd_en_c  = 1'b1;
          rd_idx_c = rd_next_c;
        end
        if (cnt_q == CW'(BW - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_OPERATE: begin
        if (tensor_core_done_in) begin
          res_d   = tensor_core_result_in;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Read beat from the result buffer; lanes past the last element read 0
    for (int unsigned l = 0; l < LANES; l++) begin
      if (rd_idx_c * LANES + l < NE) begin
        rd_data_c[l*DATA_WIDTH +: DATA_WIDTH] =
          res_q[(rd_idx_c * LANES + l)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (rd_en_c) begin
      out_d   = rd_data_c;
      valid_d = 1'b1;
    end

    // Write beat into operand storage; matrix1 first, then matrix2
    if (wr_en_c) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (32'(cnt_q) * LANES + l < NE) begin
          m1_d[(32'(cnt_q) * LANES + l)*DATA_WIDTH +: DATA_WIDTH] =
            instruction_in[l*DATA_WIDTH +: DATA_WIDTH];
        end else if (!m1only_q && (32'(cnt_q) * LANES + l < 2 * NE)) begin
          m2_d[(32'(cnt_q) * LANES + l - NE)*DATA_WIDTH +: DATA_WIDTH] =
            instruction_in[l*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign controller_output_out  = out_q;
  assign output_valid_out       = valid_q;
  assign busy_out               = busy_q;
  assign tensor_core_start_out  = start_q;
  assign tensor_core_select_out = sel_q;
  assign tensor_core_input1_out = m1_q;
  assign tensor_core_input2_out = m2_q;

endmodule

// File: doc/tensor_core_stream_controller.md
# tensor_core_stream_controller

Parametrised instruction/burst controller for the tensor core: decodes a packed instruction stream, moves operand matrices in and results out in multi-lane bursts, and drives the tensor core through a start/done handshake. It generalises matrix dimension, element width and lanes per beat. It adds a matrix1-only write burst, a latched result buffer and a single-edge output path. It sits between the host instruction bus and the tensor core datapath.

## Interface
- DATA_WIDTH, 8, signed element width in bits
- DIM, 3, matrix dimension (DIM x DIM); legal range 2..8
- LANES, 2, elements per burst beat; LANES*DATA_WIDTH must be >= 6
- clock_in  input  1  single clock; all logic on posedge
- reset_in  input  1  asynchronous, active-high reset
- instruction_in  input  LANES*DATA_WIDTH  command word in IDLE, write data during write beats
- controller_output_out  output  LANES*DATA_WIDTH  registered read-burst data; lane k in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- output_valid_out  output  1  high while controller_output_out carries a read beat
- busy_out  output  1  high whenever state != IDLE
- tensor_core_start_out  output  1  one-cycle start pulse
- tensor_core_select_out  output  2  matrix_operation_select, held from the OPERATE command
- tensor_core_done_in  input  1  tensor core completion, one-cycle pulse
- tensor_core_input1_out  output  DIM*DIM*DATA_WIDTH  matrix1 storage, flat, element r*DIM+c at slice index r*DIM+c
- tensor_core_input2_out  output  DIM*DIM*DATA_WIDTH  matrix2 storage, same packing
- tensor_core_result_in  input  DIM*DIM*DATA_WIDTH  tensor core result, same packing

## Operation
- Command word fields: [1:0] opcode (00 NOP, 01 OPERATE, 10 BURST, 11 reserved/NOP); [3:2] select; [5:4] auto-operate select (see Configuration).
- BURST select: 00 READ, 01 WRITE, 10 READ_AND_WRITE, 11 MATRIX1_WRITE.
- Commands are decoded only in IDLE. In any other state, instruction_in is write data or is ignored. No command is queued.
- States: IDLE, WRITE, READ, READ_WRITE, OPERATE.
- Beat counts:
  - BW = ceil(2*DIM*DIM/LANES) for WRITE and READ_WRITE.
  - B1 = ceil(DIM*DIM/LANES) for MATRIX1_WRITE.
  - BR = ceil(DIM*DIM/LANES) for READ.
- Element order on write: element e = beat*LANES + lane, row-major, matrix1 elements 0..DIM*DIM-1 first, then matrix2. MATRIX1_WRITE writes matrix1 only; matrix2 is untouched. Lanes beyond the last element are ignored.
- Read source: the result buffer, row-major. Lanes beyond the last element output 0.
- OPERATE: latch select[3:2] into tensor_core_select_out, pulse tensor_core_start_out, wait in OPERATE for tensor_core_done_in. On done, capture tensor_core_result_in into the result buffer and return to IDLE.
- READ_WRITE runs BW write beats. Read beats run concurrently for the first BR beats. Reads come from the result buffer and writes go to operand storage, so there is no hazard.
- Operand storage drives tensor_core_input*_out continuously.

## Timing
- Reset values: all storage, the result buffer, controller_output_out, output_valid_out, busy_out, tensor_core_start_out and tensor_core_select_out are 0; state is IDLE.
- Command sampled at edge E0.
- WRITE / MATRIX1_WRITE: data beats are sampled at E1..EB. State is IDLE after EB. The next command is sampled at EB+1.
- READ: beat i is loaded into the output register at E(i), for i = 0..BR-1. output_valid_out is high for exactly BR cycles. State goes to IDLE at E(BR-1), so a command may be sampled at E(BR). At that edge valid drops, unless a new READ reloads the output.
- READ_WRITE: read beats load at E0..E(BR-1); write beats are sampled at E1..E(BW). IDLE after E(BW).
- OPERATE: tensor_core_start_out is high during the cycle after E0 only. A tensor_core_done_in sampled at any edge from E1 onward completes the operation, including done in the same cycle as start. The result is visible to a READ sampled at the following edge.
- tensor_core_done_in outside OPERATE is ignored.
- Reset asserted mid-burst or mid-OPERATE: immediate return to IDLE with all reset values. A done arriving afterwards is ignored.

## Configuration
- TENSOR_CORE_STREAM_AUTO_OPERATE_EN defined:
  - WRITE and MATRIX1_WRITE commands latch bits [5:4] as the operation select.
  - On the last write beat edge, the state goes directly to OPERATE instead of IDLE, and start pulses in the following cycle.
  - READ_WRITE does not auto-operate.
- Undefined: bits [5:4] are ignored and all writes return to IDLE.

## Test plan
- DW=8, DIM=3, LANES=2. After reset, all outputs are 0 and busy_out=0; holding reset_in high mid-WRITE returns to IDLE immediately.
- WRITE of 9 beats carrying values 1..18 -> matrix1 = 1..9 and matrix2 = 10..18 row-major; busy_out is high for 9 cycles.
- MATRIX1_WRITE of 5 beats carrying 21..30 -> matrix1 = 21..29; lane value 30 is ignored; matrix2 is unchanged.
- OPERATE with select=01, model done 4 cycles later with result r[e]=e-4 -> one start pulse, tensor_core_select_out=01, then READ yields beats (-4,-3),(-2,-1),(0,1),(2,3),(4,0) with valid high for 5 cycles.
- READ_WRITE: 5 read beats overlap 9 write beats -> output equals the previous result buffer; the storage update is correct; an OPERATE word sent on beat 3 is taken as data only.
- With the macro defined: WRITE with [5:4]=10 -> start pulses the cycle after the 9th beat edge and select=10; without the macro, no start pulse and busy_out=0 after the burst.
